adder_bist_controller: RTL and testbench
========================================

Name: adder_bist_controller

Overview:
- Built-in self-test controller for the ripple-carry adder under test.
- Sits on both sides of the adder. It drives A/B/CIN upstream and consumes the W+1-bit SUM downstream.
- Applies every {CIN,B,A} combination exhaustively and compares each SUM against a golden A+B+CIN.
- Accumulates a per-bit fault bitmap, a mismatch count and the first failing vector, so a faulty full-adder slice (for example an incorrect slice at bit 5) can be localised.

Parameters:
- W, 8: adder operand width.
- SETTLE_CYCLES, 2: clock cycles the adder is allowed to settle before SUM is sampled; must be at least 1.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- start  in  1  begin a test run; sampled only in IDLE or DONE.
- dut_a  out  W  operand A to the adder.
- dut_b  out  W  operand B to the adder.
- dut_cin  out  1  carry-in to the adder.
- dut_sum  in  W+1  SUM returned from the adder; bit W is the carry-out.
- busy  out  1  high while a run is in progress.
- done  out  1  high in DONE until the next start.
- pass  out  1  high in DONE when fail_count==0.
- fail_count  out  2W+2  number of mismatching vectors.
- fault_bitmap  out  W+1  OR of (dut_sum XOR golden) over all vectors.
- first_fail_vec  out  2W+1  {CIN,B,A} of the first mismatch.
- first_fail_valid  out  1  first_fail_vec is meaningful.

Behaviour:
- Reset: one clock, clk; reset rst is asynchronous and active-high. Every register clears on rst. State=IDLE; all outputs are 0, including dut_a/dut_b/dut_cin.
- Vector register vec[2W:0]:
  - dut_a=vec[W-1:0], dut_b=vec[2W-1:W], dut_cin=vec[2W].
  - All three are driven straight from flops, with no combinational path from inputs.
- Golden value: A+B+CIN computed at W+1 bits, zero-extended, with no truncation.
- States:
  - IDLE: busy=0.
    - start=1: vec<=0, settle_cnt<=0, and all results cleared (fail_count, fault_bitmap, first_fail_vec, first_fail_valid).
    - Then go to SETTLE.
  - SETTLE: busy=1; settle_cnt increments each cycle.
    - When settle_cnt==SETTLE_CYCLES-1, go to CHECK.
  - CHECK: busy=1; dut_sum is sampled this cycle.
    - Mismatch: fail_count+=1 and fault_bitmap|=(dut_sum^golden).
    - If first_fail_valid==0 on a mismatch: capture first_fail_vec<=vec and set first_fail_valid.
    - If vec is all ones, go to DONE. Otherwise vec<=vec+1, settle_cnt<=0, go to SETTLE.
  - DONE: busy=0, done=1, pass=(fail_count==0).
    - Results hold.
    - start=1 restarts exactly as from IDLE, and done falls the next cycle.
- Timing:
  - Each vector takes SETTLE_CYCLES+1 cycles.
  - A full run takes 2^(2W+1)*(SETTLE_CYCLES+1) cycles after start, plus 1 cycle to enter DONE.
- Boundary conditions:
  - start while busy is ignored.
  - fail_count width holds 2^(2W+1), so it never wraps.
  - The vec wrap from all ones never occurs, because DONE is taken first.
  - rst mid-run returns to IDLE immediately and discards all results.
- pass and done are 0 outside DONE.

Optional Feature:
- Macro: ADDER_BIST_STOP_ON_FAIL_EN.
- Defined: in CHECK, the first mismatch goes to DONE immediately after updating the results. fail_count ends at 1, and the vector stays applied on dut_a/dut_b/dut_cin for inspection.
- Undefined: the run always covers all vectors.

Test Plan:
- Golden adder, W=8, SETTLE_CYCLES=2, start pulse:
  - done rises 393217 cycles after start.
  - pass=1, fail_count=0, fault_bitmap=9'h000, first_fail_valid=0.
- Adder with dut_sum[5] stuck at 0:
  - fault_bitmap=9'h020, fail_count=65536, pass=0.
  - first_fail_vec=17'h00020 (A=32, B=0, CIN=0).
- Same stuck-at fault, ADDER_BIST_STOP_ON_FAIL_EN defined:
  - done rises after 33 vectors (99 cycles + 1).
  - fail_count=1, dut_a=32, dut_b=0, dut_cin=0.
- Carry-out stuck at 0:
  - fault_bitmap=9'h100.
  - first_fail_vec has A=255, B=1, CIN=0, i.e. 17'h001FF.
- rst asserted at vector 1000 mid-run:
  - Outputs are 0 the same cycle and state is IDLE.
  - A new start gives a clean full run with results matching the first scenario.
- start pulsed again while busy:
  - Ignored; vec sequence continues uninterrupted and done timing is unchanged.

Source files
------------

// File: rtl/adder_bist_controller.sv
// Exhaustive BIST controller for a W-bit ripple-carry adder: sweeps every {CIN,B,A} vector,
// checks SUM against A+B+CIN. Optional `ADDER_BIST_STOP_ON_FAIL_EN halts at the first mismatch.
module adder_bist_controller #(
  parameter int W             = 8,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic [W-1:0]     dut_a,
  output logic [W-1:0]     dut_b,
  output logic             dut_cin,
  input  logic [W:0]       dut_sum,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [2*W+1:0]   fail_count,
  output logic [W:0]       fault_bitmap,
  output logic [2*W:0]     first_fail_vec,
  output logic             first_fail_valid
);

  localparam int VW  = 2 * W + 1;
  localparam int CW  = 2 * W + 2;
  localparam int SCW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, SETTLE, CHECK, DONE} state_t;

  state_t          state_q, state_d;
  logic [VW-1:0]   vec_q, vec_d;
  logic [SCW-1:0]  settle_q, settle_d;
  logic [CW-1:0]   fail_q, fail_d;
  logic [W:0]      bitmap_q, bitmap_d;
  logic [VW-1:0]   ffv_q, ffv_d;
  logic            ffvalid_q, ffvalid_d;

  logic [W:0]      golden;
  logic            mismatch;

  // Golden sum is formed at full W+1 width so the carry-out is checked too.
  assign golden   = {1'b0, vec_q[W-1:0]} + {1'b0, vec_q[2*W-1:W]} + {{W{1'b0}}, vec_q[2*W]};
  assign mismatch = (dut_sum != golden);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      vec_q     <= '0;
      settle_q  <= '0;
      fail_q    <= '0;
      bitmap_q  <= '0;
      ffv_q     <= '0;
      ffvalid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      vec_q     <= vec_d;
      settle_q  <= settle_d;
      fail_q    <= fail_d;
      bitmap_q  <= bitmap_d;
      ffv_q     <= ffv_d;
      ffvalid_q <= ffvalid_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    vec_d     = vec_q;
    settle_d  = settle_q;
    fail_d    = fail_q;
    bitmap_d  = bitmap_q;
    ffv_d     = ffv_q;
    ffvalid_d = ffvalid_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          vec_d     = '0;
          settle_d  = '0;
          fail_d    = '0;
          bitmap_d  = '0;
          ffv_d     = '0;
          ffvalid_d = 1'b0;
          state_d   = SETTLE;
        end
      end
      SETTLE: begin
        if (settle_q == SCW'(SETTLE_CYCLES - 1)) begin
          state_d = CHECK;
        end else begin
          settle_d = settle_q + SCW'(1);
        end
      end
      CHECK: begin
        if (mismatch) begin
          fail_d   = fail_q + CW'(1);
          bitmap_d = bitmap_q | (dut_sum ^ golden);
          if (!ffvalid_q) begin
            ffv_d     = vec_q;
            ffvalid_d = 1'b1;
          end
        end
`ifdef ADDER_BIST_STOP_ON_FAIL_EN
        if (mismatch) begin
          state_d = DONE;
        end else
`endif
        // DONE is taken on the all-ones vector, so vec never wraps.
        if (&vec_q) begin
          state_d = DONE;
        end else begin
          vec_d    = vec_q + VW'(1);
          settle_d = '0;
          state_d  = SETTLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign dut_a            = vec_q[W-1:0];
  assign dut_b            = vec_q[2*W-1:W];
  assign dut_cin          = vec_q[2*W];
  assign busy             = (state_q == SETTLE) || (state_q == CHECK);
  assign done             = (state_q == DONE);
  assign pass             = (state_q == DONE) && (fail_q == '0);
  assign fail_count       = fail_q;
  assign fault_bitmap     = bitmap_q;
  assign first_fail_vec   = ffv_q;
  assign first_fail_valid = ffvalid_q;

endmodule

// File: tb/tb_adder_bist_controller.sv
// Scoreboard bench for adder_bist_controller with a behavioural adder and injectable faults (W=4).
module tb_adder_bist_controller;
  localparam int W  = 4;
  localparam int SC = 2;
  localparam int VW = 2 * W + 1;
  localparam int CW = 2 * W + 2;
  localparam int NV = 1 << VW;
  localparam int VL = SC + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [W-1:0]  dut_a, dut_b;
  logic          dut_cin;
  logic [W:0]    dut_sum;
  logic          busy, done, pass;
  logic [CW-1:0] fail_count;
  logic [W:0]    fault_bitmap;
  logic [VW-1:0] first_fail_vec;
  logic          first_fail_valid;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int runs_pushed = 0;
  int runs_checked = 0;
  int fault = 0;

  adder_bist_controller #(.W(W), .SETTLE_CYCLES(SC)) u_dut (
    .clk(clk), .rst(rst), .start(start),
    .dut_a(dut_a), .dut_b(dut_b), .dut_cin(dut_cin), .dut_sum(dut_sum),
    .busy(busy), .done(done), .pass(pass), .fail_count(fail_count),
    .fault_bitmap(fault_bitmap), .first_fail_vec(first_fail_vec),
    .first_fail_valid(first_fail_valid)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Adder under test: 1 = sum[2] stuck-0, 2 = carry-out stuck-0, 3 = sum[0] stuck-1.
  always_comb begin
    logic [W:0] s;
    s = {1'b0, dut_a} + {1'b0, dut_b} + {{W{1'b0}}, dut_cin};
    case (fault)
      1: s[2] = 1'b0;
      2: s[W] = 1'b0;
      3: s[0] = 1'b1;
      default: ;
    endcase
    dut_sum = s;
  end

  typedef struct {
    string         name;
    int            done_cycle;
    logic [CW-1:0] fc;
    logic [W:0]    bm;
    logic [VW-1:0] ffv;
    logic          ffval;
    logic          ps;
    logic [VW-1:0] final_vec;
  } exp_t;

  exp_t sb[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Expected results of a run started now; ffv is the index of the first failing vector.
  task automatic push_exp(input string nm, input int full_fc, input logic [W:0] bm,
                          input logic [VW-1:0] ffv, input logic ffval);
    exp_t e;
    e.name = nm;
    e.bm = bm;
    e.ffv = ffv;
    e.ffval = ffval;
`ifdef ADDER_BIST_STOP_ON_FAIL_EN
    if (ffval) begin
      e.fc = CW'(1);
      e.done_cycle = cyc + (int'(ffv) + 1) * VL + 1;
      e.final_vec = ffv;
    end else
`endif
    begin
      e.fc = CW'(full_fc);
      e.done_cycle = cyc + NV * VL + 1;
      e.final_vec = '1;
    end
    e.ps = (e.fc == '0);
    sb.push_back(e);
    runs_pushed++;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_runs(input int n);
    for (int k = 0; k < 6000 && runs_checked < n; k++) @(negedge clk);
  endtask

  // Monitor: pops an expectation, waits for done to rise, compares all results.
  initial begin
    exp_t e;
    logic prev;
    bit   seen;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        prev = done;
        seen = 0;
        for (int k = 0; k < 5000 && !seen; k++) begin
          @(negedge clk);
          if (done && !prev) seen = 1;
          else prev = done;
        end
        if (!seen) begin
          chk({e.name, " done_timeout"}, 64'd0, 64'd1);
        end else begin
          chk({e.name, " done_cycle"}, 64'(cyc), 64'(e.done_cycle));
          chk({e.name, " fail_count"}, 64'(fail_count), 64'(e.fc));
          chk({e.name, " fault_bitmap"}, 64'(fault_bitmap), 64'(e.bm));
          chk({e.name, " ff_valid"}, 64'(first_fail_valid), 64'(e.ffval));
          chk({e.name, " ff_vec"}, 64'(first_fail_vec), 64'(e.ffv));
          chk({e.name, " pass"}, 64'(pass), 64'(e.ps));
          chk({e.name, " busy"}, 64'(busy), 64'd0);
          chk({e.name, " final_vec"}, 64'({dut_cin, dut_b, dut_a}), 64'(e.final_vec));
        end
        $display("run %s checked at cycle %0d", e.name, cyc);
        runs_checked++;
      end
    end
  end

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset busy", 64'(busy), 64'd0);
    chk("reset done", 64'(done), 64'd0);
    chk("reset pass", 64'(pass), 64'd0);
    chk("reset fail_count", 64'(fail_count), 64'd0);
    chk("reset bitmap", 64'(fault_bitmap), 64'd0);
    chk("reset ffvalid", 64'(first_fail_valid), 64'd0);
    chk("reset vec", 64'({dut_cin, dut_b, dut_a}), 64'd0);

    fault = 0;
    push_exp("golden", 0, 5'h00, 9'h000, 1'b0);
    pulse_start();
    chk("golden busy", 64'(busy), 64'd1);
    wait_runs(runs_pushed);

    fault = 1;
    push_exp("sum2_sa0", 256, 5'h04, 9'h004, 1'b1);
    pulse_start();
    chk("restart done falls", 64'(done), 64'd0);
    chk("restart busy", 64'(busy), 64'd1);
    wait_runs(runs_pushed);

    fault = 2;
    push_exp("cout_sa0", 256, 5'h10, 9'h01F, 1'b1);
    pulse_start();
    wait_runs(runs_pushed);

    fault = 3;
    push_exp("sum0_sa1", 256, 5'h01, 9'h000, 1'b1);
    pulse_start();
    wait_runs(runs_pushed);

    fault = 0;
    push_exp("start_while_busy", 0, 5'h00, 9'h000, 1'b0);
    pulse_start();
    repeat (50) @(negedge clk);
    pulse_start();
    chk("busy after extra start", 64'(busy), 64'd1);
    wait_runs(runs_pushed);

    // Abort a run at vector 100 (A=4, B=6, CIN=0); no result is expected from it.
    fault = 1;
    pulse_start();
    repeat (VL * 100) @(negedge clk);
    chk("midrun vec", 64'({dut_cin, dut_b, dut_a}), 64'h064);
    chk("midrun fails seen", 64'(fail_count != '0), 64'd1);
    #2 rst = 1'b1;
    #1;
    chk("rst busy", 64'(busy), 64'd0);
    chk("rst done", 64'(done), 64'd0);
    chk("rst fail_count", 64'(fail_count), 64'd0);
    chk("rst bitmap", 64'(fault_bitmap), 64'd0);
    chk("rst ffvalid", 64'(first_fail_valid), 64'd0);
    chk("rst vec", 64'({dut_cin, dut_b, dut_a}), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("idle after rst", 64'(busy | done), 64'd0);

    fault = 0;
    push_exp("after_rst", 0, 5'h00, 9'h000, 1'b0);
    pulse_start();
    wait_runs(runs_pushed);
    chk("all runs checked", 64'(runs_checked), 64'(runs_pushed));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
